// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: frame geometry, the packer FSM
// encoding and the RGB565 field layout as seen in the big-endian byte pair.
package cam_pkg;

    // Default frame geometry (QQVGA)
    localparam int unsigned DEF_WIDTH    = 160;
    localparam int unsigned DEF_HEIGHT   = 120;
    localparam int unsigned FRAME_PIXELS = DEF_WIDTH * DEF_HEIGHT;

    // Packer FSM encoding
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetchHi = 3'd1,
        StLatchHi = 3'd2,
        StFetchLo = 3'd3,
        StLatchLo = 3'd4,
        StWrite   = 3'd5,
        StDone    = 3'd6
    } pack_state_e;

    // RGB565 fields split across the byte pair {hi, lo}:
    //   hi = R[4:0] G[5:3], lo = G[2:0] B[4:0]
    localparam int unsigned HI_R_MSB = 7;
    localparam int unsigned HI_R_LSB = 3;
    localparam int unsigned HI_G_MSB = 2;
    localparam int unsigned HI_G_LSB = 0;
    localparam int unsigned LO_G_MSB = 7;
    localparam int unsigned LO_G_LSB = 5;
    localparam int unsigned LO_B_MSB = 4;
    localparam int unsigned LO_B_LSB = 0;

    // Pixels in a frame of the given geometry
    function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/rgb565_to_rgb332.sv
// Combinational RGB565 -> RGB332 reduction: keeps the top bits of each channel.
// Shared with the display path.
module rgb565_to_rgb332
    import cam_pkg::*;
(
    input  logic [7:0] hi,
    input  logic [7:0] lo,
    output logic [7:0] rgb332
);

    // R[4:2] from hi, G[5:3] from hi, B[4:3] from lo
    assign rgb332 = {hi[HI_R_MSB -: 3], hi[HI_G_MSB -: 3], lo[LO_B_MSB -: 2]};

    // Low-order channel bits are intentionally dropped
    logic unused_bits;
    assign unused_bits = ^{hi[HI_R_LSB +: 2], lo[LO_G_MSB:LO_G_LSB], lo[LO_B_MSB-2:LO_B_LSB]};

endmodule

// File: rtl/pixel_packer.sv
// Pops RGB565 byte pairs from the capture FIFO, converts them to RGB332 and
// writes one full frame into the frame buffer per start request.
module pixel_packer
    import cam_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [7:0]        fifo_data,
    output logic              fifo_rd,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pix_count
);

    localparam int unsigned       FramePixels = frame_pixels(WIDTH, HEIGHT);
    localparam logic [ADDR_W-1:0] LastAddr    = ADDR_W'(FramePixels - 1);

    pack_state_e       state;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        pixel;

    // The low byte is taken straight off fifo_data in StLatchLo
    rgb565_to_rgb332 u_conv (
        .hi     (hi_byte),
        .lo     (fifo_data),
        .rgb332 (pixel)
    );

    // Pop is decoded from the current state and live empty flag so an empty FIFO
    // is never popped and the read data lands exactly in the following latch state.
    always_comb begin
        fifo_rd = 1'b0;
        if ((state == StFetchHi || state == StFetchLo) && !fifo_empty) begin
            fifo_rd = 1'b1;
        end
    end

    // Packer FSM with registered frame-buffer and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            hi_byte    <= 8'h00;
            addr       <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pix_count  <= '0;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        pix_count <= '0;
                        addr      <= '0;
                        busy      <= 1'b1;
                        state     <= StFetchHi;
                    end
                end
                StFetchHi: begin
                    if (!fifo_empty) begin
                        state <= StLatchHi;
                    end
                end
                StLatchHi: begin
                    hi_byte <= fifo_data;
                    state   <= StFetchLo;
                end
                StFetchLo: begin
                    // Stalling here keeps hi_byte, so pairing survives FIFO gaps
                    if (!fifo_empty) begin
                        state <= StLatchLo;
                    end
                end
                StLatchLo: begin
                    fb_data <= pixel;
                    fb_addr <= addr;
                    fb_we   <= 1'b1;
                    state   <= StWrite;
                end
                StWrite: begin
                    pix_count <= pix_count + ADDR_W'(1);
                    if (pix_count == LastAddr) begin
                        // addr is left on the last pixel; it never steps past the frame
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= StDone;
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        state <= StFetchHi;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Downstream consumer of the camera capture stage's byte FIFO.
- Pops RGB565 byte pairs (high byte first) and converts each pair to RGB332.
- Writes pixels sequentially into the frame-buffer RAM, one pixel per address, for one full frame per start request.
- Reports progress and frame completion to the cube-colour detection logic.

Parameters:
WIDTH, 160, pixels per line
HEIGHT, 120, lines per frame
ADDR_W, 15, frame-buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to pack one frame; ignored while busy
fifo_empty  input  1  capture FIFO empty flag
fifo_data  input  8  capture FIFO read data; valid the cycle after fifo_rd is high
fifo_rd  output  1  FIFO pop strobe, one cycle per byte
fb_we  output  1  frame-buffer write enable, one cycle per pixel
fb_addr  output  ADDR_W  frame-buffer write address
fb_data  output  8  RGB332 pixel
busy  output  1  high from the cycle after start until frame_done
frame_done  output  1  one-cycle pulse after the last pixel write
pix_count  output  ADDR_W  pixels written in the current or last frame

Behaviour:
- Reset: synchronous to clk, active-high. All outputs 0, state IDLE, internal hi-byte register 0.
- FSM states: IDLE, FETCH_HI, LATCH_HI, FETCH_LO, LATCH_LO, WRITE, DONE.
- IDLE:
  - On start, clear pix_count and the address counter to 0, set busy, go to FETCH_HI.
  - start is only sampled in IDLE.
- FETCH_HI: if fifo_empty=0, assert fifo_rd for exactly one cycle and go to LATCH_HI. Otherwise stay, with fifo_rd=0. Never pop an empty FIFO.
- LATCH_HI: capture fifo_data into the hi register, go to FETCH_LO.
- FETCH_LO: same rule as FETCH_HI, then go to LATCH_LO.
- LATCH_LO: form the pixel and register fb_data = {hi[7:5], hi[2:0], lo[4:3]}, i.e. R[4:2], G[5:3], B[4:3]. Go to WRITE.
- WRITE:
  - fb_we=1 for one cycle, with fb_addr equal to the current address.
  - Then increment the address and pix_count.
  - If pix_count was WIDTH*HEIGHT-1, go to DONE; otherwise go to FETCH_HI.
- DONE: frame_done=1 for one cycle, busy cleared, go to IDLE. fb_addr holds the last address; pix_count holds WIDTH*HEIGHT.
- Throughput and latency:
  - Minimum 5 cycles per pixel with a non-empty FIFO. Upstream FIFO reads run slower, so no backpressure beyond fifo_empty is needed.
  - Latency from start to the first fb_we is 5 cycles with a non-empty FIFO.
- Boundaries:
  - fifo_empty asserting between the hi and lo bytes stalls in FETCH_LO; the hi byte is retained, so there is no pixel misalignment.
  - The address never exceeds WIDTH*HEIGHT-1; there is no wrap within a frame.
  - A new start after DONE restarts at address 0.
- Reset mid-frame returns to IDLE immediately and discards any partial pixel. The next start begins at address 0.
- fb_we and fifo_rd are never high in the same cycle.

Decomposition:
- Shared package (cam_pkg):
  - FSM state encoding localparams.
  - FRAME_PIXELS = WIDTH*HEIGHT.
  - RGB565 field bit positions.
- Sub-module rgb565_to_rgb332 (combinational, hi/lo in, 8-bit out). It is reused by the display path.

Test Plan:
1. Reset, then start with the FIFO preloaded with 0xF8, 0x1F -> exactly one write, fb_we at addr 0, fb_data=0xE3, 5 cycles after start, fifo_rd pulsed twice.
2. Pair 0x07, 0xE0 (pure green) -> fb_data=0x1C; pair 0x00, 0x00 -> 0x00; pair 0xFF, 0xFF -> 0xFF.
3. fifo_empty held high after the hi byte for 20 cycles, then the lo byte 0x1F arrives -> no fifo_rd while empty, single write with the correct pixel, no extra pops.
4. WIDTH=4, HEIGHT=2, continuous stream -> 8 writes at addr 0..7, frame_done pulses once, 1 cycle after the addr-7 write, pix_count=8, busy low afterwards.
5. start pulsed while busy -> ignored, address sequence uninterrupted; start after frame_done -> first write at addr 0.
6. reset asserted after 3 pixels, mid-FETCH_LO -> all outputs 0 the next cycle; a new start writes its first pixel at addr 0 with the correct byte pairing.
